// File: rtl/apb_requester_if.sv
// rtl/apb_requester_if.sv - command/response port and APB bus bundle for apb_requester
interface apb_requester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_requester.sv
// rtl/apb_requester.sv - single-outstanding APB initiator with wait-state timeout
module apb_requester #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic                  i_pclk,
  input  logic                  i_preset,
  apb_requester_if.master       bus
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_rsp_timeout;
  logic              w_psel;
  logic              w_penable;
  logic              w_cmd_ready;
  logic              w_fire;
  logic              w_done;
  logic              w_abort;

  assign w_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_done  = (r_state == S_ACCESS) && bus.pready;
  // pready on the final wait cycle takes priority over the abort
  assign w_abort = (TIMEOUT_CYCLES != 0) && (r_state == S_ACCESS) && !bus.pready && (r_cnt == TO_LAST);

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_fire) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_psel      = (r_state == S_SETUP) || (r_state == S_ACCESS);
    w_penable   = (r_state == S_ACCESS);
    w_cmd_ready = (r_state == S_IDLE) && !i_preset && (!r_rsp_valid || bus.rsp_ready);
  end

  always_ff @(posedge i_pclk or posedge i_preset) begin
    if (i_preset) begin
      r_cnt         <= '0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (r_state == S_SETUP) r_cnt <= '0;
      else if ((r_state == S_ACCESS) && !bus.pready) r_cnt <= r_cnt + CNT_W'(1);

      if (w_fire) begin
        r_pwrite <= bus.cmd_write;
        r_paddr  <= bus.cmd_addr;
        r_pwdata <= bus.cmd_wdata;
      end

      // a new completion always overwrites the slot, even during its handshake
      if (w_done) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= r_pwrite ? '0 : bus.prdata;
        r_rsp_err     <= bus.pslverr;
        r_rsp_timeout <= 1'b0;
      end else if (w_abort) begin
        r_rsp_valid   <= 1'b1;
        r_rsp_rdata   <= '0;
        r_rsp_err     <= 1'b1;
        r_rsp_timeout <= 1'b1;
      end else if (r_rsp_valid && bus.rsp_ready) begin
        r_rsp_valid   <= 1'b0;
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.psel        = w_psel;
  assign bus.penable     = w_penable;
  assign bus.pwrite      = r_pwrite;
  assign bus.paddr       = r_paddr;
  assign bus.pwdata      = r_pwdata;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_rdata   = r_rsp_rdata;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_requester.sv
// tb/tb_apb_requester.sv - directed self-checking bench for apb_requester
module tb_apb_requester;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  apb_requester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_requester #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .i_pclk   (clk),
    .i_preset (rst),
    .bus      (bus.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b1; bus.prdata = '0; bus.pready = 1'b1; bus.pslverr = 1'b0;
    #1;
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_paddr", bus.paddr, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", bus.cmd_ready, 1);

    // zero-wait write
    cmd(1'b1, 32'h8, 32'hA5A5_0001);
    tick();
    bus.cmd_valid = 1'b0;
    chk("w_setup_psel", bus.psel, 1);
    chk("w_setup_penable", bus.penable, 0);
    chk("w_setup_paddr", bus.paddr, 32'h8);
    chk("w_setup_pwdata", bus.pwdata, 32'hA5A5_0001);
    chk("w_setup_pwrite", bus.pwrite, 1);
    chk("w_setup_cmd_ready", bus.cmd_ready, 0);
    tick();
    chk("w_access_penable", bus.penable, 1);
    chk("w_access_psel", bus.psel, 1);
    tick();
    chk("w_rsp_valid", bus.rsp_valid, 1);
    chk("w_rsp_err", bus.rsp_err, 0);
    chk("w_rsp_rdata", bus.rsp_rdata, 0);
    chk("w_done_psel", bus.psel, 0);
    tick();
    chk("w_rsp_clear", bus.rsp_valid, 0);

    // read with three wait states
    cmd(1'b0, 32'h4, 32'hFFFF_FFFF);
    bus.pready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    chk("r_setup_pwrite", bus.pwrite, 0);
    tick(); tick(); tick();
    chk("r_wait_penable", bus.penable, 1);
    chk("r_wait_paddr", bus.paddr, 32'h4);
    chk("r_wait_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("r_access4_penable", bus.penable, 1);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_1ABC;
    tick();
    chk("r_rsp_valid", bus.rsp_valid, 1);
    chk("r_rsp_rdata", bus.rsp_rdata, 32'h1ABC);
    chk("r_rsp_err", bus.rsp_err, 0);
    chk("r_done_psel", bus.psel, 0);
    tick();

    // completer error
    cmd(1'b0, 32'h0, 32'h0);
    bus.pslverr = 1'b1;
    bus.prdata  = 32'hDEAD;
    tick();
    bus.cmd_valid = 1'b0;
    tick(); tick();
    chk("e_rsp_valid", bus.rsp_valid, 1);
    chk("e_rsp_err", bus.rsp_err, 1);
    chk("e_rsp_timeout", bus.rsp_timeout, 0);
    chk("e_rsp_rdata", bus.rsp_rdata, 32'hDEAD);
    bus.pslverr = 1'b0;
    tick();

    // timeout after 16 ACCESS cycles
    cmd(1'b0, 32'hC, 32'h0);
    bus.pready = 1'b0;
    bus.prdata = 32'h5555;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("t_access16_penable", bus.penable, 1);
    chk("t_access16_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("t_psel", bus.psel, 0);
    chk("t_penable", bus.penable, 0);
    chk("t_rsp_valid", bus.rsp_valid, 1);
    chk("t_rsp_err", bus.rsp_err, 1);
    chk("t_rsp_timeout", bus.rsp_timeout, 1);
    chk("t_rsp_rdata", bus.rsp_rdata, 0);
    bus.pready = 1'b1;
    tick();
    chk("t_rsp_clear", bus.rsp_valid, 0);

    // response backpressure
    bus.rsp_ready = 1'b0;
    cmd(1'b1, 32'h10, 32'h1234);
    tick();
    cmd(1'b1, 32'h14, 32'h5678);
    tick(); tick();
    chk("b_rsp_valid", bus.rsp_valid, 1);
    chk("b_cmd_ready", bus.cmd_ready, 0);
    tick(); tick();
    chk("b_hold_psel", bus.psel, 0);
    chk("b_hold_rsp_valid", bus.rsp_valid, 1);
    chk("b_hold_rsp_err", bus.rsp_err, 0);
    chk("b_hold_rsp_rdata", bus.rsp_rdata, 0);
    chk("b_hold_paddr", bus.paddr, 32'h10);
    bus.rsp_ready = 1'b1;
    #1;
    chk("b_release_cmd_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    chk("b_next_psel", bus.psel, 1);
    chk("b_next_paddr", bus.paddr, 32'h14);
    chk("b_next_rsp_valid", bus.rsp_valid, 0);
    tick(); tick();
    chk("b_next_rsp", bus.rsp_valid, 1);
    tick();

    // reset in the middle of ACCESS
    cmd(1'b1, 32'h18, 32'h99);
    bus.pready = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    chk("x_pre_penable", bus.penable, 1);
    rst = 1'b1;
    #1;
    chk("x_psel", bus.psel, 0);
    chk("x_penable", bus.penable, 0);
    chk("x_rsp_valid", bus.rsp_valid, 0);
    chk("x_cmd_ready", bus.cmd_ready, 0);
    #1;
    rst = 1'b0;
    bus.pready = 1'b1;
    tick();
    chk("x_idle_psel", bus.psel, 0);
    chk("x_idle_rsp_valid", bus.rsp_valid, 0);
    cmd(1'b1, 32'h1C, 32'h77);
    tick();
    bus.cmd_valid = 1'b0;
    chk("x_new_paddr", bus.paddr, 32'h1C);
    tick(); tick();
    chk("x_new_rsp_valid", bus.rsp_valid, 1);
    chk("x_new_rsp_err", bus.rsp_err, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
